// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: carries the ALU result and memory/writeback controls
// into MEM, owns the {Z,V,N} flag register and the sticky halt indication.
module ex_mem_stage #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          valid_in,
    input  logic [3:0]    opcode_in,
    input  logic [DW-1:0] alu_result_in,
    input  logic          alu_ovfl_in,
    input  logic [DW-1:0] store_data_in,
    input  logic [RW-1:0] dst_reg_in,
    input  logic          reg_write_in,
    input  logic          mem_read_in,
    input  logic          mem_write_in,
    output logic          valid_out,
    output logic [3:0]    opcode_out,
    output logic [DW-1:0] alu_result_out,
    output logic [DW-1:0] store_data_out,
    output logic [RW-1:0] dst_reg_out,
    output logic          reg_write_out,
    output logic          mem_read_out,
    output logic          mem_write_out,
    output logic [2:0]    flags_out,
    output logic          halted
);

    // Flow control: flush beats stall; stall holds everything; otherwise one
    // instruction (real or not, per valid_in) is taken every edge. Halt freezes all.
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2;
    localparam logic [3:0] OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t     state_q, state_d;
    logic       capture, bubble, is_hlt, ctrl_en;
    logic [2:0] flags_d;
    logic       res_zero;

    assign is_hlt   = (opcode_in == OP_HLT);
    assign ctrl_en  = valid_in & ~is_hlt;
    assign res_zero = (alu_result_in == '0);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        bubble  = 1'b0;
        if (state_q == ST_RUN) begin
            if (flush) begin
                bubble = 1'b1;
            end else if (!stall) begin
                capture = 1'b1;
                if (valid_in && is_hlt) state_d = ST_HALT;
            end
        end
    end

    // flags_out is {Z,V,N}
    always_comb begin
        flags_d = flags_out;
        if (capture && valid_in) begin
            unique case (opcode_in)
                OP_ADD, OP_SUB:                 flags_d = {res_zero, alu_ovfl_in, alu_result_in[DW-1]};
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d = {res_zero, flags_out[1:0]};
                default:                        flags_d = flags_out;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign halted = (state_q == ST_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out      <= 1'b0;
            opcode_out     <= '0;
            alu_result_out <= '0;
            store_data_out <= '0;
            dst_reg_out    <= '0;
            reg_write_out  <= 1'b0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            flags_out      <= '0;
        end else if (bubble) begin
            valid_out      <= 1'b0;
            opcode_out     <= '0;
            alu_result_out <= '0;
            store_data_out <= '0;
            dst_reg_out    <= '0;
            reg_write_out  <= 1'b0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
        end else if (capture) begin
            valid_out      <= valid_in;
            opcode_out     <= opcode_in;
            alu_result_out <= alu_result_in;
            store_data_out <= store_data_in;
            dst_reg_out    <= dst_reg_in;
            // HLT travels as a real instruction with no side effects in MEM/WB
            reg_write_out  <= reg_write_in & ctrl_en;
            mem_read_out   <= mem_read_in & ctrl_en;
            mem_write_out  <= mem_write_in & ctrl_en;
            flags_out      <= flags_d;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: table of vectors with hand-derived expectations,
// plus hand-written stall/flush/halt/reset sequences.
module tb_ex_mem_stage;

  localparam int DW = 16;
  localparam int RW = 4;
  localparam int EW = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, flush, valid_in;
  logic [3:0]    opcode_in;
  logic [DW-1:0] alu_result_in, store_data_in;
  logic          alu_ovfl_in;
  logic [RW-1:0] dst_reg_in;
  logic          reg_write_in, mem_read_in, mem_write_in;
  logic          valid_out;
  logic [3:0]    opcode_out;
  logic [DW-1:0] alu_result_out, store_data_out;
  logic [RW-1:0] dst_reg_out;
  logic          reg_write_out, mem_read_out, mem_write_out;
  logic [2:0]    flags_out;
  logic          halted;

  ex_mem_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .opcode_in(opcode_in), .alu_result_in(alu_result_in), .alu_ovfl_in(alu_ovfl_in),
    .store_data_in(store_data_in), .dst_reg_in(dst_reg_in), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .valid_out(valid_out),
    .opcode_out(opcode_out), .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .dst_reg_out(dst_reg_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .flags_out(flags_out), .halted(halted)
  );

  // clock/reset
  always #5 clk = ~clk;

  typedef struct {
    logic          stall, flush, valid;
    logic [3:0]    op;
    logic [DW-1:0] res;
    logic          ovfl;
    logic [DW-1:0] sd;
    logic [RW-1:0] dst;
    logic          rw, mr, mw;
    logic [EW-1:0] exp;
  } vec_t;

  vec_t          tbl[12];
  vec_t          v;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] act;
  logic [EW-1:0] held;
  int            n_checks = 0;
  int            n_fail = 0;

  assign act = {valid_out, opcode_out, alu_result_out, store_data_out, dst_reg_out,
                reg_write_out, mem_read_out, mem_write_out, flags_out, halted};

  // packs {valid,op,result,store,dst,rw,mr,mw,flags,halted}
  function automatic logic [EW-1:0] pk(input logic vld, input logic [3:0] op,
                                       input logic [DW-1:0] res, input logic [DW-1:0] sd,
                                       input logic [RW-1:0] dst, input logic rw, input logic mr,
                                       input logic mw, input logic [2:0] fl, input logic h);
    return {vld, op, res, sd, dst, rw, mr, mw, fl, h};
  endfunction

  // scoreboard compare
  task automatic check(input string name);
    logic [EW-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry queued, got %h", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end
    end
  endtask

  // driver: apply one vector, queue its expectation, sample #1 after the edge
  task automatic drive(input vec_t d, input string name);
    stall = d.stall; flush = d.flush; valid_in = d.valid; opcode_in = d.op;
    alu_result_in = d.res; alu_ovfl_in = d.ovfl; store_data_in = d.sd; dst_reg_in = d.dst;
    reg_write_in = d.rw; mem_read_in = d.mr; mem_write_in = d.mw;
    exp_q.push_back(d.exp);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    //            stl fl vld op     res       ov sd        dst  rw mr mw  expected
    tbl[0]  = '{0, 0, 1, 4'h0, 16'h0000, 1, 16'h1234, 4'h3, 1, 0, 0, pk(1, 4'h0, 16'h0000, 16'h1234, 4'h3, 1, 0, 0, 3'b110, 0)};
    tbl[1]  = '{0, 0, 1, 4'h1, 16'h8001, 0, 16'h0000, 4'h4, 1, 0, 0, pk(1, 4'h1, 16'h8001, 16'h0000, 4'h4, 1, 0, 0, 3'b001, 0)};
    tbl[2]  = '{0, 0, 1, 4'h2, 16'h0000, 0, 16'h0000, 4'h5, 1, 0, 0, pk(1, 4'h2, 16'h0000, 16'h0000, 4'h5, 1, 0, 0, 3'b101, 0)};
    tbl[3]  = '{0, 0, 1, 4'h0, 16'h7FFF, 1, 16'h0000, 4'h6, 1, 0, 0, pk(1, 4'h0, 16'h7FFF, 16'h0000, 4'h6, 1, 0, 0, 3'b010, 0)};
    tbl[4]  = '{0, 0, 1, 4'h3, 16'hFFF8, 0, 16'h0000, 4'h7, 1, 0, 0, pk(1, 4'h3, 16'hFFF8, 16'h0000, 4'h7, 1, 0, 0, 3'b010, 0)};
    tbl[5]  = '{0, 0, 1, 4'h4, 16'h0010, 0, 16'h0000, 4'h1, 1, 0, 0, pk(1, 4'h4, 16'h0010, 16'h0000, 4'h1, 1, 0, 0, 3'b010, 0)};
    tbl[6]  = '{0, 0, 0, 4'h0, 16'h0000, 0, 16'h5555, 4'h2, 1, 1, 1, pk(0, 4'h0, 16'h0000, 16'h5555, 4'h2, 0, 0, 0, 3'b010, 0)};
    tbl[7]  = '{0, 0, 1, 4'h8, 16'h0040, 0, 16'h0000, 4'h5, 1, 1, 0, pk(1, 4'h8, 16'h0040, 16'h0000, 4'h5, 1, 1, 0, 3'b010, 0)};
    tbl[8]  = '{0, 0, 1, 4'h9, 16'h0044, 0, 16'hBEEF, 4'h0, 0, 0, 1, pk(1, 4'h9, 16'h0044, 16'hBEEF, 4'h0, 0, 0, 1, 3'b010, 0)};
    tbl[9]  = '{0, 0, 1, 4'h7, 16'h0000, 1, 16'h0000, 4'h8, 1, 0, 0, pk(1, 4'h7, 16'h0000, 16'h0000, 4'h8, 1, 0, 0, 3'b010, 0)};
    tbl[10] = '{0, 0, 1, 4'h5, 16'h0000, 0, 16'h0000, 4'h9, 1, 0, 0, pk(1, 4'h5, 16'h0000, 16'h0000, 4'h9, 1, 0, 0, 3'b110, 0)};
    tbl[11] = '{0, 0, 1, 4'h6, 16'h8000, 0, 16'h0000, 4'hA, 1, 0, 0, pk(1, 4'h6, 16'h8000, 16'h0000, 4'hA, 1, 0, 0, 3'b010, 0)};

    stall = 0; flush = 0; valid_in = 0; opcode_in = '0; alu_result_in = '0; alu_ovfl_in = 0;
    store_data_in = '0; dst_reg_in = '0; reg_write_in = 0; mem_read_in = 0; mem_write_in = 0;

    // reset is asynchronous: outputs clear before any clock edge
    rst = 1'b1;
    #1;
    exp_q.push_back('0);
    check("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) drive(tbl[i], $sformatf("vec%0d", i));

    // LW held off by 3 stall cycles, plus a flag-changing ADD under stall
    held = tbl[11].exp;
    v = '{1, 0, 1, 4'h8, 16'h0100, 0, 16'h0000, 4'hC, 1, 1, 0, held};
    for (int i = 0; i < 3; i++) drive(v, $sformatf("lw_stall%0d", i));
    v = '{1, 0, 1, 4'h0, 16'h0000, 1, 16'h0000, 4'hC, 1, 0, 0, held};
    drive(v, "add_stall");
    v = '{0, 0, 1, 4'h8, 16'h0100, 0, 16'h0000, 4'hC, 1, 1, 0,
          pk(1, 4'h8, 16'h0100, 16'h0000, 4'hC, 1, 1, 0, 3'b010, 0)};
    drive(v, "lw_release");

    // flush wins over stall
    held = pk(0, 4'h0, 16'h0000, 16'h0000, 4'h0, 0, 0, 0, 3'b010, 0);
    v = '{1, 1, 1, 4'h9, 16'h0200, 0, 16'h1111, 4'h3, 0, 0, 1, held};
    drive(v, "sw_flush_stall");

    // HLT under flush is discarded, under stall waits
    v = '{0, 1, 1, 4'hF, 16'h0300, 0, 16'h2222, 4'hD, 1, 1, 1, held};
    drive(v, "hlt_flush");
    v = '{1, 0, 1, 4'hF, 16'h0300, 0, 16'h2222, 4'hD, 1, 1, 1, held};
    drive(v, "hlt_stall");

    // HLT captured: real instruction, no controls, sticky halt
    held = pk(1, 4'hF, 16'h0300, 16'h2222, 4'hD, 0, 0, 0, 3'b010, 1);
    v = '{0, 0, 1, 4'hF, 16'h0300, 0, 16'h2222, 4'hD, 1, 1, 1, held};
    drive(v, "hlt_capture");
    v = '{0, 0, 1, 4'h0, 16'h0000, 1, 16'h0000, 4'h1, 1, 0, 0, held};
    drive(v, "halted_add");
    v = '{0, 1, 1, 4'h1, 16'h8000, 0, 16'h0000, 4'h2, 1, 0, 0, held};
    drive(v, "halted_flush");

    // reset mid-halt clears immediately, without waiting for an edge
    rst = 1'b1;
    #2;
    exp_q.push_back('0);
    check("reset_mid_halt");
    @(posedge clk);
    #1;
    rst = 1'b0;
    v = '{0, 0, 1, 4'h0, 16'h0000, 0, 16'h0000, 4'h1, 1, 0, 0,
          pk(1, 4'h0, 16'h0000, 16'h0000, 4'h1, 1, 0, 0, 3'b100, 0)};
    drive(v, "add_after_reset");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
